// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and framing constants.
// Used by both the receive and transmit paths.
package uart_pkg;

  localparam int CLKS_PER_BIT_DFLT = 868;
  localparam int DATA_BITS         = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Parametric first-word-fall-through synchronous FIFO.
// Head word is visible on dout_o whenever empty_o is low.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  // A push into a full FIFO is only taken when a pop frees the slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: rx synchronizer, 8N1 deserializer FSM, receive FIFO.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err port.
module uart_rx_path import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overflow,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_e state_q, state_d;
  logic [1:0]  sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        fe_q, fe_d;
  logic        ovf_q, ovf_d;
  logic        rx_s, push, pop, full, empty, keep;

`ifdef UART_RX_PARITY_EN
  logic        bad_q, bad_d;
  logic        pe_q, pe_d;
  assign parity_err = pe_q;
  assign keep       = !bad_q;
`else
  assign keep       = 1'b1;
`endif

  assign rx_s      = sync_q[1];
  assign rx_valid  = !empty;
  assign pop       = rx_valid && rx_ready;
  assign frame_err = fe_q;
  assign overflow  = ovf_q;

  // Two-flop synchronizer, FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      fe_q      <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], rx};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      fe_q      <= fe_d;
      ovf_q     <= ovf_d;
`ifdef UART_RX_PARITY_EN
      bad_q     <= bad_d;
      pe_q      <= pe_d;
`endif
    end
  end

  // Next state: every bit is sampled at its midpoint.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fe_d      = 1'b0;
    ovf_d     = 1'b0;
    push      = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_d     = bad_q;
    pe_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            bad_d     = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          if (rx_s != ^shift_q) begin
            bad_d = 1'b1;
            pe_d  = 1'b1;
          end
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          if (rx_s) begin
            push    = keep;
            ovf_d   = keep && full && !pop;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (shift_q),
    .pop_i   (pop),
    .dout_o  (rx_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_path.sv
// Testbench for uart_rx_path: random frames against a byte-queue model.
// Runs with CLKS_PER_BIT=16, DEPTH=4.
module tb_uart_rx_path;

  localparam int C = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fifo_count;

  int  n_chk = 0;
  int  n_err = 0;
  byte unsigned exp_q[$];
  int  fe_seen = 0, fe_exp = 0;
  int  ovf_seen = 0, ovf_exp = 0;
  bit  ready_rand = 0;

  uart_rx_path #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random consumer back-pressure.
  always @(posedge clk) begin
    if (ready_rand) begin
      #1 rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Per-cycle scoreboard: occupancy, head data on every pop, pulse counts.
  always @(negedge clk) begin
    if (!rst) begin
      check("rx_valid", {31'd0, rx_valid}, {31'd0, exp_q.size() != 0});
      check("fifo_count", {29'd0, fifo_count}, exp_q.size());
      fe_seen  += int'(frame_err);
      ovf_seen += int'(overflow);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
        else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // One frame. The stop sample lands 154 edges after the start edge;
  // the model decides push/overflow from the state seen in that cycle.
  task automatic send(input logic [7:0] b, input bit stop_bit,
                      input bit pulse);
    bit pop_now;
    bit push_pend;
    push_pend = 0;
    @(posedge clk) #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (C) @(posedge clk);
    #1 rx = stop_bit;
    repeat (10) @(posedge clk);
    #1 if (pulse) rx_ready = 1'b1;
    #1 pop_now = rx_valid && rx_ready;
    if (!stop_bit) fe_exp++;
    else if (exp_q.size() < D || pop_now) push_pend = 1;
    else ovf_exp++;
    @(posedge clk) #1 if (pulse) rx_ready = 1'b0;
    #1 if (push_pend) exp_q.push_back(b);
    repeat (5) @(posedge clk);
  endtask

  task automatic drain();
    ready_rand = 0;
    @(posedge clk) #1 rx_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_empty", exp_q.size(), 0);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("drain_count", {29'd0, fifo_count}, 0);
  endtask

  task automatic pulses(input string tag);
    check({tag, "_fe"}, fe_seen, fe_exp);
    check({tag, "_ovf"}, ovf_seen, ovf_exp);
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_count", {29'd0, fifo_count}, 0);
    check("rst_pulses", {30'd0, frame_err, overflow}, 0);
    rst = 1'b0;
    repeat (2 * C) @(posedge clk);

    // Single byte held in the FIFO.
    send(8'hA5, 1, 0);
    @(negedge clk);
    check("a5_valid", {31'd0, rx_valid}, 1);
    check("a5_data", {24'd0, rx_data}, 8'hA5);
    check("a5_count", {29'd0, fifo_count}, 1);
    pulses("a5");
    drain();

    // Back-to-back frames with a ready consumer.
    @(posedge clk) #1 rx_ready = 1'b1;
    send(8'h01, 1, 0);
    send(8'h80, 1, 0);
    send(8'hFF, 1, 0);
    drain();
    pulses("b2b");

    // Short low glitch is rejected, then a normal frame.
    @(posedge clk) #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    check("glitch_count", {29'd0, fifo_count}, 0);
    pulses("glitch");
    send(8'h6B, 1, 0);
    drain();

    // Bad stop followed by a long break: one frame_err only.
    send(8'h3C, 0, 0);
    repeat (40 * C) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    pulses("break");
    check("break_count", {29'd0, fifo_count}, 0);
    send(8'h55, 1, 0);
    pulses("after_break");
    drain();

    // Fill past capacity: fifth byte dropped with overflow.
    for (int i = 0; i < 5; i++) send(8'($urandom), 1, 0);
    repeat (4) @(posedge clk);
    check("ovf_count", {29'd0, fifo_count}, D);
    pulses("ovf");
    drain();

    // Same, but a pop coincides with the fifth push.
    for (int i = 0; i < 5; i++) send(8'($urandom), 1, i == 4);
    repeat (4) @(posedge clk);
    check("simul_count", {29'd0, fifo_count}, D);
    pulses("simul");
    drain();

    // Reset in the middle of a frame with data buffered.
    send(8'h9A, 1, 0);
    b = 8'h77;
    @(posedge clk) #1 rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (C) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_data", {24'd0, rx_data}, 0);
    check("mid_rst_valid", {31'd0, rx_valid}, 0);
    check("mid_rst_count", {29'd0, fifo_count}, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * C) @(posedge clk);
    send(8'h12, 1, 0);
    @(negedge clk);
    check("post_rst_data", {24'd0, rx_data}, 8'h12);
    drain();

    // Random bytes, random back-pressure, occasional bad stop bits.
    ready_rand = 1;
    for (int i = 0; i < 24; i++) begin
      bit good;
      good = ($urandom_range(0, 7) != 0);
      send(8'($urandom), good, 0);
      if (!good) begin
        #1 rx = 1'b1;
        repeat (C) @(posedge clk);
      end
    end
    drain();
    pulses("random");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
